// File: rtl/axi_w_order_arbiter.sv
// axi_w_order_arbiter
//   Write-data scheduler for one AXI initiator port. Each AW grant on this
//   port records the one-hot index of the target port that won it in a
//   circular grant FIFO. The head grant steers that target's W beats to the
//   initiator port one burst at a time. The grant is released on the wlast
//   handshake.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   push_i, push_sel_i  AW handshake on this port and its one-hot owner
//   push_ready_o        grant FIFO has space (gates AW ready upstream)
//   wvalid_i, wlast_i   per-target W valid / last
//   wready_o            per-target W ready (only the selected target)
//   sel_o               one-hot W data mux select, zero when idle
//   wvalid_o, wlast_o   W valid / last toward the initiator port
//   wready_i            W ready from the initiator port
//   pending_o           number of stored grants
//   beat_cnt_o          beats accepted in the current burst, saturating
//
// Configuration
//   AXI_W_ARB_BYPASS_EN  when defined, an AW pushed into an empty FIFO
//                        selects its target in the same cycle.

module axi_w_order_arbiter #(
  parameter int N_TARG_PORT = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push_i,
  input  logic [N_TARG_PORT-1:0]           push_sel_i,
  output logic                             push_ready_o,
  input  logic [N_TARG_PORT-1:0]           wvalid_i,
  input  logic [N_TARG_PORT-1:0]           wlast_i,
  output logic [N_TARG_PORT-1:0]           wready_o,
  output logic [N_TARG_PORT-1:0]           sel_o,
  output logic                             wvalid_o,
  output logic                             wlast_o,
  input  logic                             wready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  pending_o,
  output logic [7:0]                       beat_cnt_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [N_TARG_PORT-1:0] mem_q [FIFO_DEPTH];
  logic [N_TARG_PORT-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [7:0]             beat_cnt_q, beat_cnt_d;

  logic [N_TARG_PORT-1:0] head_s;
  logic                   hs_s;
  logic                   pop_s;
  logic                   bypass_pop_s;
  logic                   push_en_s;
  logic                   pop_en_s;

  // Circular pointer advance, wrapping at FIFO_DEPTH (need not be a power of 2).
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Head select: stored head grant, or (bypass build) the grant arriving now.
  always_comb begin
    head_s = '0;
    if (count_q != '0) begin
      head_s = mem_q[rd_ptr_q];
    end else begin
`ifdef AXI_W_ARB_BYPASS_EN
      head_s = push_i ? push_sel_i : '0;
`else
      head_s = '0;
`endif
    end
  end

  assign push_ready_o = (count_q < CNT_FULL);
  assign sel_o        = head_s;
  assign wvalid_o     = |(wvalid_i & head_s);
  assign wlast_o      = |(wlast_i & head_s);
  assign wready_o     = head_s & {N_TARG_PORT{wready_i}};
  assign pending_o    = count_q;
  assign beat_cnt_o   = beat_cnt_q;

  assign hs_s  = wvalid_o & wready_i;
  assign pop_s = hs_s & wlast_o;

`ifdef AXI_W_ARB_BYPASS_EN
  // A single-beat burst completed in its own AW cycle never occupies a slot.
  assign bypass_pop_s = (count_q == '0) & push_i & pop_s;
`else
  assign bypass_pop_s = 1'b0;
`endif

  // Full FIFO refuses the push even when a pop happens in the same cycle.
  assign push_en_s = push_i & push_ready_o & ~bypass_pop_s;
  assign pop_en_s  = pop_s & (count_q != '0);

  // Next-state for grant storage, pointers, count and beat counter.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    beat_cnt_d = beat_cnt_q;

    if (push_en_s) begin
      mem_d[wr_ptr_q] = push_sel_i;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_en_s) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_en_s, pop_en_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (pop_s) begin
      beat_cnt_d = 8'd0;
    end else if (hs_s) begin
      beat_cnt_d = (beat_cnt_q == 8'd255) ? beat_cnt_q : beat_cnt_q + 8'd1;
    end else begin
      beat_cnt_d = beat_cnt_q;
    end
  end

  // State registers; reset discards every stored grant and the beat count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      beat_cnt_q <= 8'd0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
